// File: rtl/sprite_renderer_pkg.sv
// Shared raster timing and colour-index definitions for the video pipeline.
// Used by the sprite renderer and the downstream colour mux.
package sprite_renderer_pkg;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 784;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 515;

  localparam int TRANSPARENT_IDX = 0;

  // Fetch runs this many pixels ahead so registered outputs line up with the raster.
  localparam int LOOKAHEAD = 2;

  typedef enum logic [2:0] {
    CIDX_TRANSPARENT = 3'd0,
    CIDX_BLACK       = 3'd1,
    CIDX_WHITE       = 3'd2,
    CIDX_RED         = 3'd3,
    CIDX_GREEN       = 3'd4,
    CIDX_BLUE        = 3'd5,
    CIDX_YELLOW      = 3'd6,
    CIDX_CYAN        = 3'd7
  } cidx_e;

  function automatic logic [10:0] lookahead_col(input logic [9:0] h);
    return {1'b0, h} + 11'(LOOKAHEAD);
  endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Sprite ROM bus: renderer presents a texel address, ROM returns the index one clock later.
interface sprite_renderer_if #(
  parameter int AW    = 11,
  parameter int CIDXW = 3
);

  logic [AW-1:0]    rom_addr;
  logic [CIDXW-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/sprite_renderer_anim_ctr.sv
// Frame-start detect plus the animation divider that selects the sprite frame in ROM.
module sprite_renderer_anim_ctr #(
  parameter int NFRAMES  = 2,
  parameter int ANIM_DIV = 8,
  localparam int FW      = $clog2(NFRAMES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hCount,
  input  logic [9:0]    vCount,
  output logic          frame_start,
  output logic [FW-1:0] frame_sel
);

  localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [ACW-1:0] ANIM_LAST = ACW'(ANIM_DIV - 1);

  logic [ACW-1:0] anim_cnt_q, anim_cnt_d;
  logic [FW-1:0]  frame_sel_q, frame_sel_d;

  always_comb begin
    frame_start = (hCount == 10'd0) && (vCount == 10'd0);
    anim_cnt_d  = anim_cnt_q;
    frame_sel_d = frame_sel_q;
    if (frame_start) begin
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_d  = '0;
        // NFRAMES is a power of two, so natural overflow gives the modulo wrap.
        frame_sel_d = frame_sel_q + FW'(1);
      end else begin
        anim_cnt_d = anim_cnt_q + ACW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anim_cnt_q  <= '0;
      frame_sel_q <= '0;
    end else begin
      anim_cnt_q  <= anim_cnt_d;
      frame_sel_q <= frame_sel_d;
    end
  end

  assign frame_sel = frame_sel_q;

endmodule

// File: rtl/sprite_renderer.sv
// Single scalable, animated bitmap sprite: fetches texels two pixels ahead of the raster
// so spr_drawing/spr_indx are registered yet aligned with the current hCount/vCount.
module sprite_renderer #(
  parameter int CIDXW      = 3,
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int NFRAMES    = 2,
  parameter int SCALE_LOG2 = 1,
  parameter int ANIM_DIV   = 8,
  localparam int AW        = $clog2(NFRAMES * SPR_W * SPR_H),
  localparam int FW        = $clog2(NFRAMES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          hCount,
  input  logic [9:0]          vCount,
  input  logic [9:0]          spr_x,
  input  logic [9:0]          spr_y,
  input  logic                spr_en,
  input  logic                spr_flip,
  sprite_renderer_if.master   rom,
  output logic                spr_drawing,
  output logic [CIDXW-1:0]    spr_indx,
  output logic [FW-1:0]       frame_sel
);

  import sprite_renderer_pkg::*;

  localparam int TXW = $clog2(SPR_W);
  localparam int TYW = $clog2(SPR_H);

  localparam logic [10:0]      SPR_W_L   = 11'(SPR_W);
  localparam logic [9:0]       SPR_H_L   = 10'(SPR_H);
  localparam logic [10:0]      H_LIMIT   = 11'(H_TOTAL);
  localparam logic [9:0]       V_LIMIT   = 10'(V_TOTAL);
  localparam logic [TXW-1:0]   TX_LAST   = TXW'(SPR_W - 1);
  localparam logic [CIDXW-1:0] CIDX_NONE = CIDXW'(TRANSPARENT_IDX);

  logic frame_start;

  sprite_renderer_anim_ctr #(
    .NFRAMES  (NFRAMES),
    .ANIM_DIV (ANIM_DIV)
  ) u_anim_ctr (
    .clk         (clk),
    .reset       (reset),
    .hCount      (hCount),
    .vCount      (vCount),
    .frame_start (frame_start),
    .frame_sel   (frame_sel)
  );

  // Shadow copies of the sprite controls, frozen for the whole frame.
  logic [9:0]       sx_q, sx_d;
  logic [9:0]       sy_q, sy_d;
  logic             sh_en_q, sh_en_d;
  logic             sh_flip_q, sh_flip_d;

  logic             hit_a_q, hit_a_d;
  logic             spr_drawing_q, spr_drawing_d;
  logic [CIDXW-1:0] spr_indx_q, spr_indx_d;

  logic [10:0]    hl;
  logic [10:0]    dx;
  logic [10:0]    dx_s;
  logic [9:0]     dy;
  logic [9:0]     dy_s;
  logic [TXW-1:0] tx_raw;
  logic [TXW-1:0] tx;
  logic [TYW-1:0] ty;
  logic [AW-1:0]  rom_addr_w;

  always_comb begin
    sx_d      = sx_q;
    sy_d      = sy_q;
    sh_en_d   = sh_en_q;
    sh_flip_d = sh_flip_q;
    if (frame_start) begin
      sx_d      = spr_x;
      sy_d      = spr_y;
      sh_en_d   = spr_en;
      sh_flip_d = spr_flip;
    end
  end

  // Stage A: address generation for the pixel two columns ahead.
  always_comb begin
    hl     = lookahead_col(hCount);
    dx     = hl - {1'b0, sx_q};
    dy     = vCount - sy_q;
    dx_s   = dx >> SCALE_LOG2;
    dy_s   = dy >> SCALE_LOG2;
    tx_raw = dx_s[TXW-1:0];
    ty     = dy_s[TYW-1:0];
    tx     = sh_flip_q ? (TX_LAST - tx_raw) : tx_raw;

    // Columns 800/801 fall off the line; no wrap into the next one.
    hit_a_d = sh_en_q
           && (hl >= {1'b0, sx_q}) && (hl < H_LIMIT)
           && (vCount >= sy_q) && (vCount < V_LIMIT)
           && (dx_s < SPR_W_L) && (dy_s < SPR_H_L);

    rom_addr_w = reset ? '0 : {frame_sel, ty, tx};
  end

  // Stage B: ROM data for the fetch issued last cycle is present now.
  always_comb begin
    spr_indx_d    = hit_a_q ? rom.rom_data : CIDX_NONE;
    spr_drawing_d = hit_a_q && (rom.rom_data != CIDX_NONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q          <= '0;
      sy_q          <= '0;
      sh_en_q       <= 1'b0;
      sh_flip_q     <= 1'b0;
      hit_a_q       <= 1'b0;
      spr_drawing_q <= 1'b0;
      spr_indx_q    <= '0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      sh_en_q       <= sh_en_d;
      sh_flip_q     <= sh_flip_d;
      hit_a_q       <= hit_a_d;
      spr_drawing_q <= spr_drawing_d;
      spr_indx_q    <= spr_indx_d;
    end
  end

  assign rom.rom_addr = rom_addr_w;
  assign spr_drawing  = spr_drawing_q;
  assign spr_indx     = spr_indx_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: the bench plays both raster generator and sprite ROM.
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h_count, v_count, spr_x, spr_y;
  logic       spr_en, spr_flip;
  logic       spr_drawing;
  logic [2:0] spr_indx;
  logic       frame_sel;

  logic [2:0] mem [2048];

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_anim = 0;
  logic exp_fsel = 1'b0;

  sprite_renderer_if rom_if ();

  sprite_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .hCount      (h_count),
    .vCount      (v_count),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
    .spr_flip    (spr_flip),
    .rom         (rom_if),
    .spr_drawing (spr_drawing),
    .spr_indx    (spr_indx),
    .frame_sel   (frame_sel)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM model.
  always @(posedge clk) rom_if.rom_data <= mem[rom_if.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic px(input int h, input int v, input bit check, input bit ed, input int ei);
    @(posedge clk);
    #1;
    h_count = 10'(h);
    v_count = 10'(v);
    #1;
    if (check) begin
      chk($sformatf("draw(%0d,%0d)", h, v), 32'(spr_drawing), 32'(ed));
      chk($sformatf("indx(%0d,%0d)", h, v), 32'(spr_indx), 32'(ei));
      chk($sformatf("addr_msb(%0d,%0d)", h, v), 32'(rom_if.rom_addr[10]), 32'(exp_fsel));
    end
  endtask

  // Drives columns h0-2..h1 of row v, checking h0..h1; opaque expected on dlo..dhi.
  task automatic span(input int v, input int h0, input int h1, input int dlo, input int dhi,
                      input int idx);
    for (int h = h0 - 2; h <= h1; h++) begin
      px(h, v, (h >= h0), (h >= dlo && h <= dhi), (h >= dlo && h <= dhi) ? idx : 0);
    end
  endtask

  task automatic frame_start();
    px(0, 0, 1'b0, 1'b0, 0);
    if (exp_anim == 7) begin
      exp_anim = 0;
      exp_fsel = ~exp_fsel;
    end else begin
      exp_anim++;
    end
  endtask

  task automatic fill_rom(input logic [2:0] val);
    for (int i = 0; i < 2048; i++) mem[i] = val;
  endtask

  initial begin
    fill_rom(3'd0);
    mem[0]   = 3'd5;
    reset    = 1'b1;
    h_count  = 10'd5;
    v_count  = 10'd5;
    spr_x    = 10'd0;
    spr_y    = 10'd0;
    spr_en   = 1'b0;
    spr_flip = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_drawing", 32'(spr_drawing), 32'd0);
    chk("rst_indx", 32'(spr_indx), 32'd0);
    chk("rst_rom_addr", 32'(rom_if.rom_addr), 32'd0);
    chk("rst_frame_sel", 32'(frame_sel), 32'd0);
    reset = 1'b0;

    // Mid-line reset after the sprite is visible.
    spr_x  = 10'd300;
    spr_y  = 10'd200;
    spr_en = 1'b1;
    frame_start();
    span(200, 296, 304, 300, 301, 5);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      h_count = 10'(298 + i);
      v_count = 10'd201;
      #1;
      chk("midrst_drawing", 32'(spr_drawing), 32'd0);
      chk("midrst_indx", 32'(spr_indx), 32'd0);
      chk("midrst_frame_sel", 32'(frame_sel), 32'd0);
    end
    reset    = 1'b0;
    exp_anim = 0;
    exp_fsel = 1'b0;
    px(301, 201, 1'b1, 1'b0, 0);
    span(201, 296, 304, 1, 0, 0);

    // Single texel (0,0) at (300,200), 2x scale.
    frame_start();
    span(199, 296, 304, 1, 0, 0);
    span(200, 296, 304, 300, 301, 5);
    span(201, 296, 304, 300, 301, 5);
    span(202, 296, 304, 1, 0, 0);
    px(330, 203, 1'b0, 1'b0, 0);
    chk("addr_noflip", 32'(rom_if.rom_addr), 32'd48);

    // Mirrored: texel 0 lands at screen texel column 31.
    spr_flip = 1'b1;
    frame_start();
    span(200, 358, 366, 362, 363, 5);
    span(201, 358, 366, 362, 363, 5);
    span(200, 296, 304, 1, 0, 0);
    px(330, 203, 1'b0, 1'b0, 0);
    chk("addr_flip", 32'(rom_if.rom_addr), 32'd47);

    // Mid-frame position change stays hidden until the next frame start.
    spr_flip = 1'b0;
    spr_y    = 10'd260;
    frame_start();
    px(10, 250, 1'b0, 1'b0, 0);
    spr_x = 10'd400;
    span(260, 296, 304, 300, 301, 5);
    span(260, 396, 404, 1, 0, 0);
    frame_start();
    span(260, 396, 404, 400, 401, 5);
    span(260, 296, 304, 1, 0, 0);

    // Right-edge clipping with an opaque sprite, then the next line's head.
    fill_rom(3'd3);
    spr_x = 10'd790;
    spr_y = 10'd100;
    frame_start();
    for (int h = 786; h <= 799; h++) px(h, 100, (h >= 788), (h >= 790), (h >= 790) ? 3 : 0);
    for (int h = 0; h <= 7; h++) px(h, 101, 1'b1, 1'b0, 0);

    // Sprite entirely below the raster.
    spr_x = 10'd0;
    spr_y = 10'd600;
    frame_start();
    span(524, 2, 20, 1, 0, 0);

    // Animation: frame 0 shows index 5, frame 1 shows index 6 at texel (0,0).
    fill_rom(3'd0);
    mem[0]    = 3'd5;
    mem[1024] = 3'd6;
    spr_x     = 10'd300;
    spr_y     = 10'd200;
    for (int f = 0; f < 20; f++) begin
      frame_start();
      px(10, 10, 1'b0, 1'b0, 0);
      chk($sformatf("frame_sel_f%0d", f), 32'(frame_sel), 32'(exp_fsel));
      span(200, 300, 303, 300, 301, exp_fsel ? 6 : 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
